cnt_down2: RTL and testbench

Two-digit BCD down-counter (countdown timer), 00–99. It is the counterpart of the team's two-digit BCD up-counter: same digit outputs (`out1` tens, `out0` ones), but it counts down from a loaded value. On reaching 00 it pulses `DONE`, so it can drive a timer or display stage directly.

---
 rtl/cnt_pkg.sv | 17 +
 rtl/bcd_digit_dn.sv | 30 +++
 rtl/cnt_down2.sv | 160 ++++++++++++++++
 tb/tb_cnt_down2.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the two-digit BCD counters: FSM state encoding,
// the largest legal BCD digit and a digit-validity helper.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } cnt_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit of a down-counter: combinational next value and borrow,
// chained ones -> tens through borrow_out -> dec_in.
module bcd_digit_dn
  import cnt_pkg::*;
(
  input  logic       dec_in,
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o,
  output logic       borrow_out
);

  // Decrement with wrap 0 -> 9, reporting the borrow to the next digit
  always_comb begin
    digit_o    = digit_i;
    borrow_out = 1'b0;
    if (dec_in) begin
      if (digit_i == 4'd0) begin
        digit_o    = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_o    = digit_i - 4'd1;
        borrow_out = 1'b0;
      end
    end else begin
      digit_o    = digit_i;
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/cnt_down2.sv
// Two-digit BCD countdown timer (00-99) with load, start/stop, prescaled
// decrement, one-cycle DONE pulse and sticky ERR for non-BCD loads.
module cnt_down2
  import cnt_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       CLK0,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] LD1,
  input  logic [3:0] LD0,
  input  logic       START,
  input  logic       STOP,
  output logic [3:0] out1,
  output logic [3:0] out0,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  cnt_state_e    state_q, state_d;
  logic [3:0]    cnt1_q, cnt1_d;
  logic [3:0]    cnt0_q, cnt0_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          tick_s;
  logic          load_ok_s;
  logic          is_zero_s;
  logic          is_one_s;
  logic [3:0]    dig0_s, dig1_s;
  logic          borrow0_s, borrow1_s;

  assign tick_s    = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign load_ok_s = is_bcd(LD1) && is_bcd(LD0);
  assign is_zero_s = (cnt1_q == 4'd0) && (cnt0_q == 4'd0);
  assign is_one_s  = (cnt1_q == 4'd0) && (cnt0_q == 4'd1);

  bcd_digit_dn u_ones (
    .dec_in     (tick_s),
    .digit_i    (cnt0_q),
    .digit_o    (dig0_s),
    .borrow_out (borrow0_s)
  );

  bcd_digit_dn u_tens (
    .dec_in     (borrow0_s),
    .digit_i    (cnt1_q),
    .digit_o    (dig1_s),
    .borrow_out (borrow1_s)
  );

  // Next-state logic; priority LOAD > STOP > START > tick
  always_comb begin
    state_d = state_q;
    cnt1_d  = cnt1_q;
    cnt0_d  = cnt0_q;
    presc_d = presc_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (LOAD) begin
      state_d = IDLE;
      if (load_ok_s) begin
        cnt1_d  = LD1;
        cnt0_d  = LD0;
        err_d   = 1'b0;
        presc_d = PRESC_ZERO;
      end else begin
        err_d   = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (START && !err_q) begin
            if (is_zero_s) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              presc_d = PRESC_ZERO;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (STOP) begin
            // prescaler is frozen so a resume keeps the partial period
            state_d = HOLD;
          end else if (tick_s) begin
            presc_d = PRESC_ZERO;
            if (!borrow1_s) begin
              cnt1_d = dig1_s;
              cnt0_d = dig0_s;
            end else begin
              cnt1_d = cnt1_q;
              cnt0_d = cnt0_q;
            end
            if (is_one_s) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        HOLD: begin
          if (START) begin
            state_d = RUN;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK0) begin
    if (RST) begin
      state_q <= IDLE;
      cnt1_q  <= 4'd0;
      cnt0_q  <= 4'd0;
      presc_q <= PRESC_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt1_q  <= cnt1_d;
      cnt0_q  <= cnt0_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out1 = cnt1_q;
  assign out0 = cnt0_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_cnt_down2.sv
// Scoreboard bench for cnt_down2: stimulus pushes per-cycle expectations,
// a monitor pops and compares after every clock edge.
module tb_cnt_down2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] ld1 = 4'd0;
  logic [3:0] ld0 = 4'd0;

  logic [3:0] a_o1, a_o0, b_o1, b_o0;
  logic       a_busy, a_done, a_err, b_busy, b_done, b_err;

  cnt_down2 #(.TICK_DIV(1)) u_a (
    .CLK0(clk), .RST(rst), .LOAD(load), .LD1(ld1), .LD0(ld0),
    .START(start), .STOP(stop),
    .out1(a_o1), .out0(a_o0), .BUSY(a_busy), .DONE(a_done), .ERR(a_err)
  );

  cnt_down2 #(.TICK_DIV(4)) u_b (
    .CLK0(clk), .RST(rst), .LOAD(load), .LD1(ld1), .LD0(ld0),
    .START(start), .STOP(stop),
    .out1(b_o1), .out0(b_o0), .BUSY(b_busy), .DONE(b_done), .ERR(b_err)
  );

  typedef struct {
    logic       sel;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       err;
    int         step;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [10:0] mon_got;
  logic [10:0] mon_exp;
  int         total = 0;
  int         bad = 0;
  int         step_n = 0;

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic cyc(input logic sel, input logic r, input logic ld,
                     input logic [3:0] d1, input logic [3:0] d0,
                     input logic st, input logic sp,
                     input int n, input logic eb, input logic ed, input logic ee);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; ld1 = d1; ld0 = d0; start = st; stop = sp;
    e.sel = sel; e.cnt = bcd(n); e.busy = eb; e.done = ed; e.err = ee;
    e.step = step_n;
    step_n++;
    sb_q.push_back(e);
  endtask

  task automatic idl(input logic sel, input int n, input logic eb, input logic ed, input logic ee);
    cyc(sel, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, n, eb, ed, ee);
  endtask

  task automatic ldv(input logic sel, input logic [3:0] d1, input logic [3:0] d0,
                     input int n, input logic ee);
    cyc(sel, 1'b0, 1'b1, d1, d0, 1'b0, 1'b0, n, 1'b0, 1'b0, ee);
  endtask

  task automatic stt(input logic sel, input int n, input logic eb, input logic ed, input logic ee);
    cyc(sel, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, n, eb, ed, ee);
  endtask

  task automatic stp(input logic sel, input int n, input logic eb);
    cyc(sel, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, n, eb, 1'b0, 1'b0);
  endtask

  task automatic rsv(input logic sel);
    cyc(sel, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one comparison per clock edge that has a pending expectation
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_got = mon_e.sel ? {b_o1, b_o0, b_busy, b_done, b_err}
                          : {a_o1, a_o0, a_busy, a_done, a_err};
      mon_exp = {mon_e.cnt, mon_e.busy, mon_e.done, mon_e.err};
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL step%0d dut%0d: got out=%h busy=%b done=%b err=%b, want out=%h busy=%b done=%b err=%b",
                 mon_e.step, mon_e.sel, mon_got[10:3], mon_got[2], mon_got[1], mon_got[0],
                 mon_exp[10:3], mon_exp[2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  initial begin
    // Reset and basic countdown, TICK_DIV=1
    rsv(1'b0);
    rsv(1'b0);
    ldv(1'b0, 4'd2, 4'd3, 23, 1'b0);
    stt(1'b0, 23, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 23; k++) idl(1'b0, 23 - k, (23 - k) != 0, k == 23, 1'b0);
    idl(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Zero start
    ldv(1'b0, 4'd0, 4'd0, 0, 1'b0);
    stt(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idl(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Invalid load then recovery
    ldv(1'b0, 4'd4, 4'd2, 42, 1'b0);
    ldv(1'b0, 4'd3, 4'd12, 42, 1'b1);
    stt(1'b0, 42, 1'b0, 1'b0, 1'b1);
    idl(1'b0, 42, 1'b0, 1'b0, 1'b1);
    ldv(1'b0, 4'd0, 4'd5, 5, 1'b0);
    stt(1'b0, 5, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) idl(1'b0, 5 - k, (5 - k) != 0, k == 5, 1'b0);
    idl(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Abort by LOAD at 57
    ldv(1'b0, 4'd6, 4'd0, 60, 1'b0);
    stt(1'b0, 60, 1'b1, 1'b0, 1'b0);
    idl(1'b0, 59, 1'b1, 1'b0, 1'b0);
    idl(1'b0, 58, 1'b1, 1'b0, 1'b0);
    idl(1'b0, 57, 1'b1, 1'b0, 1'b0);
    ldv(1'b0, 4'd9, 4'd9, 99, 1'b0);
    idl(1'b0, 99, 1'b0, 1'b0, 1'b0);

    // Reset mid-count, and reset dropping a pending DONE
    stt(1'b0, 99, 1'b1, 1'b0, 1'b0);
    idl(1'b0, 98, 1'b1, 1'b0, 1'b0);
    idl(1'b0, 97, 1'b1, 1'b0, 1'b0);
    rsv(1'b0);
    idl(1'b0, 0, 1'b0, 1'b0, 1'b0);
    ldv(1'b0, 4'd0, 4'd1, 1, 1'b0);
    stt(1'b0, 1, 1'b1, 1'b0, 1'b0);
    rsv(1'b0);
    idl(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Simultaneous events: LOAD+START, STOP on a tick, START in RUN
    cyc(1'b0, 1'b0, 1'b1, 4'd1, 4'd5, 1'b1, 1'b0, 15, 1'b0, 1'b0, 1'b0);
    idl(1'b0, 15, 1'b0, 1'b0, 1'b0);
    stt(1'b0, 15, 1'b1, 1'b0, 1'b0);
    stp(1'b0, 15, 1'b1);
    idl(1'b0, 15, 1'b1, 1'b0, 1'b0);
    stp(1'b0, 15, 1'b1);
    stt(1'b0, 15, 1'b1, 1'b0, 1'b0);
    idl(1'b0, 14, 1'b1, 1'b0, 1'b0);
    stt(1'b0, 13, 1'b1, 1'b0, 1'b0);
    ldv(1'b0, 4'd0, 4'd0, 0, 1'b0);
    stp(1'b0, 0, 1'b0);

    // Pause with TICK_DIV=4: prescaler held across HOLD, 40 active cycles
    rsv(1'b1);
    ldv(1'b1, 4'd1, 4'd0, 10, 1'b0);
    stt(1'b1, 10, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 10, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 10, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 10, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 9, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 9, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 9, 1'b1, 1'b0, 1'b0);
    stp(1'b1, 9, 1'b1);
    idl(1'b1, 9, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 9, 1'b1, 1'b0, 1'b0);
    stp(1'b1, 9, 1'b1);
    stt(1'b1, 9, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 9, 1'b1, 1'b0, 1'b0);
    idl(1'b1, 8, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) idl(1'b1, 8 - k / 4, (8 - k / 4) != 0, k == 32, 1'b0);
    idl(1'b1, 0, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
